// File: rtl/bsrk_i2c_calc.sv
// I2C target at I2C_ADDR in front of an 8-bit calculator register file (A, B, OP -> 16-bit RES, ovf).
// Latency: RES/ovf settle 1 clk after a write to A, B or OP; SDA moves ~SYNC_STG+1 clks after SCL falls.
// Backpressure: none, SCL is never stretched. Define CALC_MUL_EN to build the OP=3 multiplier.
module bsrk_i2c_calc #(
  parameter logic [6:0] I2C_ADDR = 7'h42,
  parameter int         SYNC_STG = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  logic [SYNC_STG-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_q, sda_q;
  logic start_det, stop_det, scl_rise, scl_fall;

  state_t     state, state_nxt;
  logic [7:0] sh, sh_nxt;
  logic [2:0] bit_cnt, cnt_nxt;
  logic       done, done_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic       rw, rw_nxt;
  logic       sda_low, sda_nxt;
  logic       wr_en;

  logic [7:0]  a, b;
  logic [1:0]  op;
  logic [15:0] res, calc_res;
  logic        ovf, calc_ovf, upd;
  logic [8:0]  sum9, dif9;
  logic [7:0]  rmap [8];
  logic [7:0]  rd_cur, rd_next;

  logic unused;
  assign unused = &{1'b0, ena, ui_in[7:1], uio_in[7:3], uio_in[0]};

  // Synchronisers idle high so leaving reset on an idle bus creates no edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STG-2:0], uio_in[2]};
      sda_sync <= {sda_sync[SYNC_STG-2:0], uio_in[1]};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STG-1];
  assign sda_s     = sda_sync[SYNC_STG-1];
  assign start_det = scl_q & scl_s & sda_q & ~sda_s;
  assign stop_det  = scl_q & scl_s & ~sda_q & sda_s;
  assign scl_rise  = ~scl_q & scl_s;
  assign scl_fall  = scl_q & ~scl_s;

  always_comb begin
    rmap[0] = a;
    rmap[1] = b;
    rmap[2] = {6'b0, op};
    rmap[3] = res[7:0];
    rmap[4] = res[15:8];
    rmap[5] = {7'b0, ovf};
    rmap[6] = 8'h00;
    rmap[7] = 8'h00;
  end

  assign rd_cur  = rmap[ptr];
  assign rd_next = rmap[ptr + 3'd1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sh_nxt    = sh;
    cnt_nxt   = bit_cnt;
    done_nxt  = done;
    ptr_nxt   = ptr;
    rw_nxt    = rw;
    sda_nxt   = sda_low;
    wr_en     = 1'b0;
    if (start_det) begin
      state_nxt = ADDR;
      cnt_nxt   = 3'd0;
      done_nxt  = 1'b0;
      sda_nxt   = 1'b0;
    end else if (stop_det) begin
      state_nxt = IDLE;
      done_nxt  = 1'b0;
      sda_nxt   = 1'b0;
    end else begin
      case (state)
        ADDR, PTR, WDATA: begin
          if (scl_rise && !done) begin
            sh_nxt   = {sh[6:0], sda_s};
            cnt_nxt  = bit_cnt + 3'd1;
            done_nxt = (bit_cnt == 3'd7);
          end else if (scl_fall && done) begin
            // Byte complete: decide on the fall so the ACK is driven for the whole 9th clock.
            done_nxt = 1'b0;
            case (state)
              ADDR: begin
                if (sh[7:1] == I2C_ADDR) begin
                  state_nxt = ADDR_ACK;
                  rw_nxt    = sh[0];
                  sda_nxt   = 1'b1;
                end else begin
                  state_nxt = IDLE;
                  sda_nxt   = 1'b0;
                end
              end
              PTR: begin
                state_nxt = PTR_ACK;
                ptr_nxt   = sh[2:0];
                sda_nxt   = 1'b1;
              end
              default: begin
                state_nxt = WDATA_ACK;
                wr_en     = 1'b1;
                ptr_nxt   = ptr + 3'd1;
                sda_nxt   = 1'b1;
              end
            endcase
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            cnt_nxt  = 3'd0;
            done_nxt = 1'b0;
            if (rw) begin
              state_nxt = RDATA;
              sh_nxt    = rd_cur;
              sda_nxt   = ~rd_cur[7];
            end else begin
              state_nxt = PTR;
              sda_nxt   = 1'b0;
            end
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            state_nxt = WDATA;
            cnt_nxt   = 3'd0;
            sda_nxt   = 1'b0;
          end
        end
        RDATA: begin
          if (scl_rise && !done) begin
            cnt_nxt  = bit_cnt + 3'd1;
            done_nxt = (bit_cnt == 3'd7);
          end else if (scl_fall) begin
            if (done) begin
              state_nxt = RDATA_ACK;
              done_nxt  = 1'b0;
              sda_nxt   = 1'b0;
            end else begin
              sh_nxt  = {sh[6:0], 1'b0};
              sda_nxt = ~sh[6];
            end
          end
        end
        RDATA_ACK: begin
          // done marks a host ACK seen on the rise; the next byte starts on the fall.
          if (scl_rise) begin
            if (sda_s) state_nxt = IDLE;
            else       done_nxt  = 1'b1;
          end else if (scl_fall && done) begin
            state_nxt = RDATA;
            ptr_nxt   = ptr + 3'd1;
            sh_nxt    = rd_next;
            sda_nxt   = ~rd_next[7];
            cnt_nxt   = 3'd0;
            done_nxt  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh      <= 8'h00;
      bit_cnt <= 3'd0;
      done    <= 1'b0;
      ptr     <= 3'd0;
      rw      <= 1'b0;
      sda_low <= 1'b0;
    end else begin
      sh      <= sh_nxt;
      bit_cnt <= cnt_nxt;
      done    <= done_nxt;
      ptr     <= ptr_nxt;
      rw      <= rw_nxt;
      sda_low <= sda_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a  <= 8'h00;
      b  <= 8'h00;
      op <= 2'd0;
    end else if (wr_en) begin
      case (ptr)
        3'd0:    a  <= sh;
        3'd1:    b  <= sh;
        3'd2:    op <= sh[1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    sum9     = {1'b0, a} + {1'b0, b};
    dif9     = {1'b0, a} - {1'b0, b};
    calc_res = 16'h0000;
    calc_ovf = 1'b0;
    case (op)
      2'd0: begin
        calc_res = {7'b0, sum9};
        calc_ovf = sum9[8];
      end
      2'd1: begin
        calc_res = {{7{dif9[8]}}, dif9};
        calc_ovf = dif9[8];
      end
      2'd2: calc_res = {a | b, a & b};
      default: begin
`ifdef CALC_MUL_EN
        calc_res = 16'(a) * 16'(b);
`else
        calc_res = 16'h0000;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd <= 1'b0;
      res <= 16'h0000;
      ovf <= 1'b0;
    end else begin
      upd <= wr_en && (ptr < 3'd3);
      if (upd) begin
        res <= calc_res;
        ovf <= calc_ovf;
      end
    end
  end

  assign uo_out  = ui_in[0] ? res[15:8] : res[7:0];
  assign uio_out = 8'h00;
  assign uio_oe  = {6'b0, sda_low, 1'b0};

endmodule

// File: tb/tb_bsrk_i2c_calc.sv
// Bench for bsrk_i2c_calc: bit-banged I2C master plus an arithmetic reference model of the register file.
module tb_bsrk_i2c_calc;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo_out, uio_in, uio_out, uio_oe;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       pulled = 1'b0;
  int         errors = 0;
  int         checks = 0;

  logic [7:0] m_a = 8'h00, m_b = 8'h00;
  logic [1:0] m_op = 2'd0;

  localparam int Q = 6;

  assign sda_line = sda_m & ~uio_oe[1];
  assign uio_in   = {5'b0, scl_m, sda_line, 1'b0};

  always #5 clk = ~clk;

  bsrk_i2c_calc dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  function automatic logic [15:0] m_res();
    int x, y, r;
    x = int'(m_a);
    y = int'(m_b);
    case (m_op)
      2'd0: r = x + y;
      2'd1: r = x - y;
      2'd2: r = (x | y) * 256 + (x & y);
      default: begin
`ifdef CALC_MUL_EN
        r = x * y;
`else
        r = 0;
`endif
      end
    endcase
    return r[15:0];
  endfunction

  function automatic logic m_ovf();
    if (m_op == 2'd0) return (int'(m_a) + int'(m_b)) > 255;
    if (m_op == 2'd1) return m_a < m_b;
    return 1'b0;
  endfunction

  function automatic logic [7:0] m_reg(input logic [2:0] p);
    logic [15:0] r;
    r = m_res();
    case (p)
      3'd0: return m_a;
      3'd1: return m_b;
      3'd2: return {6'b0, m_op};
      3'd3: return r[7:0];
      3'd4: return r[15:8];
      3'd5: return {7'b0, m_ovf()};
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_write(input logic [2:0] p, input logic [7:0] d);
    case (p)
      3'd0: m_a = d;
      3'd1: m_b = d;
      3'd2: m_op = d[1:0];
      default: ;
    endcase
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic qwait();
    repeat (Q) begin
      @(negedge clk);
      if (uio_oe[1]) pulled = 1'b1;
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b0; qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b1; qwait();
  endtask

  task automatic wbit(input logic v);
    sda_m = v; qwait();
    scl_m = 1'b1; qwait(); qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic rbit(output logic v);
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    v = sda_line; qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(s);
    ack = ~s;
  endtask

  task automatic rbyte(input logic ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      rbit(s);
      d[i] = s;
    end
    wbit(~ack);
  endtask

  task automatic wr_txn(input logic [2:0] p, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input int n);
    logic       ack;
    logic [7:0] d [3];
    d[0] = d0; d[1] = d1; d[2] = d2;
    i2c_start();
    wbyte(8'h84, ack); check("wr_addr_ack", 16'(ack), 16'd1);
    wbyte({5'b0, p}, ack); check("wr_ptr_ack", 16'(ack), 16'd1);
    for (int i = 0; i < n; i++) begin
      wbyte(d[i], ack);
      check("wr_data_ack", 16'(ack), 16'd1);
      model_write(3'(p + 3'(i)), d[i]);
    end
    i2c_stop();
  endtask

  task automatic rd_txn(input logic [2:0] p, input int n, input string tag);
    logic       ack;
    logic [7:0] d;
    i2c_start();
    wbyte(8'h84, ack); check("rd_addrw_ack", 16'(ack), 16'd1);
    wbyte({5'b0, p}, ack); check("rd_ptr_ack", 16'(ack), 16'd1);
    i2c_start();
    wbyte(8'h85, ack); check("rd_addrr_ack", 16'(ack), 16'd1);
    for (int i = 0; i < n; i++) begin
      rbyte(i != n - 1, d);
      check(tag, 16'(d), 16'(m_reg(3'(p + 3'(i)))));
    end
    i2c_stop();
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;

    rst_n = 1'b0;
    #20;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_uo_out", 16'(uo_out), 16'h00);
    check("rst_uio_oe", 16'(uio_oe), 16'h00);
    check("rst_uio_out", 16'(uio_out), 16'h00);
    repeat (5) @(negedge clk);

    // 200 + 100 = 300: carry out, RES = 0x012C
    wr_txn(3'd0, 8'hC8, 8'h64, 8'h00, 3);
    ui_in = 8'h00; repeat (3) @(negedge clk);
    check("add_uo_low", 16'(uo_out), 16'h2C);
    ui_in = 8'h01; repeat (3) @(negedge clk);
    check("add_uo_high", 16'(uo_out), 16'h01);
    ui_in = 8'h00;
    rd_txn(3'd5, 1, "add_status");
    check("add_status_model", 16'(m_reg(3'd5)), 16'h01);

    // Wrong address must never be acknowledged
    pulled = 1'b0;
    i2c_start();
    wbyte(8'h86, ack);
    check("nack_addr_43", 16'(ack), 16'd0);
    wbyte(8'h00, ack);
    i2c_stop();
    check("nack_no_pull", 16'(pulled), 16'd0);
    rd_txn(3'd0, 3, "after_nack_regs");

    // Write A, B, OP then repeated-start read continues from the incremented pointer (3)
    i2c_start();
    wbyte(8'h84, ack); check("sub_addr_ack", 16'(ack), 16'd1);
    wbyte(8'h00, ack); check("sub_ptr_ack", 16'(ack), 16'd1);
    wbyte(8'h05, ack); check("sub_a_ack", 16'(ack), 16'd1);
    wbyte(8'h07, ack); check("sub_b_ack", 16'(ack), 16'd1);
    wbyte(8'h01, ack); check("sub_op_ack", 16'(ack), 16'd1);
    m_a = 8'h05; m_b = 8'h07; m_op = 2'd1;
    i2c_start();
    wbyte(8'h85, ack); check("sub_addrr_ack", 16'(ack), 16'd1);
    rbyte(1'b1, d); check("sub_res_l", 16'(d), 16'hFE);
    rbyte(1'b1, d); check("sub_res_h", 16'(d), 16'hFF);
    rbyte(1'b0, d); check("sub_status", 16'(d), 16'h01);
    qwait();
    check("sub_nack_release", 16'(uio_oe), 16'h00);
    i2c_stop();

    wr_txn(3'd0, 8'hFF, 8'hFF, 8'h03, 3);
    rd_txn(3'd3, 3, "mul_regs");
    ui_in = 8'h01; repeat (3) @(negedge clk);
`ifdef CALC_MUL_EN
    check("mul_uo_high", 16'(uo_out), 16'hFE);
`else
    check("mul_uo_high", 16'(uo_out), 16'h00);
`endif
    ui_in = 8'h00;

    // Pointer wrap on write (7 discarded, then A, B) and on read (7, 0, 1)
    wr_txn(3'd7, 8'h11, 8'h22, 8'h33, 3);
    rd_txn(3'd7, 3, "wrap_read");
    rd_txn(3'd2, 6, "wrap_long_read");

    for (int it = 0; it < 6; it++) begin
      wr_txn(3'd0, 8'($urandom), 8'($urandom), 8'($urandom_range(0, 3)), 3);
      ui_in = {7'b0, 1'($urandom)};
      repeat (3) @(negedge clk);
      check("rand_uo_out", 16'(uo_out), 16'(ui_in[0] ? m_res() >> 8 : m_res() & 16'h00FF));
      rd_txn(3'd0, 6, "rand_regs");
    end
    ui_in = 8'h00;

    // Reset while the target is driving a 0 data bit in RDATA
    wr_txn(3'd0, 8'h12, 8'h34, 8'h02, 3);
    i2c_start();
    wbyte(8'h84, ack);
    wbyte(8'h00, ack);
    i2c_start();
    wbyte(8'h85, ack); check("mid_addrr_ack", 16'(ack), 16'd1);
    check("mid_sda_driven", 16'(uio_oe), 16'h02);
    rst_n = 1'b0;
    #1;
    check("mid_rst_oe", 16'(uio_oe), 16'h00);
    check("mid_rst_uo", 16'(uo_out), 16'h00);
    check("mid_rst_uio_out", 16'(uio_out), 16'h00);
    m_a = 8'h00; m_b = 8'h00; m_op = 2'd0;
    scl_m = 1'b1; sda_m = 1'b1;
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    rd_txn(3'd0, 6, "post_rst_regs");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
